// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// Module   : mult_pkg
// Purpose  : Shared definitions for the shift-add multiplier controller:
//            FSM state encoding, default operand width and the iteration
//            counter width derivation.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  // Default operand width; also the number of add/shift iterations.
  localparam int MULT_WIDTH = 8;

  // Controller states; codes 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Counter must hold WIDTH (reached after the final SHIFT), hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_counter.sv
// ----------------------------------------------------------------------------
// Module   : iter_counter
// Purpose  : Iteration counter for the multiplier controller. Synchronous
//            clear and increment; tc flags the last iteration (WIDTH-1).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // Count completed iterations; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : shift_add_mult_ctrl
// Purpose  : Control FSM for a sequential shift-add multiplier. Sequences
//            load, conditional add and shift once per multiplier bit and
//            pulses done after WIDTH iterations. Moore outputs only.
// Options  : MERGE_ADD_SHIFT_EN - removes the ADD state; the add enable is
//            issued together with shift_en in SHIFT using q0 captured in
//            CHECK, giving a fixed latency.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  output logic load_regs,
  output logic clr_acc,
  output logic add_en,
  output logic shift_en,
  output logic busy,
  output logic done
);

  localparam int CNT_W = cnt_width(WIDTH);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] LOAD  = ST_LOAD;
  localparam logic [2:0] CHECK = ST_CHECK;
  localparam logic [2:0] ADD   = ST_ADD;
  localparam logic [2:0] SHIFT = ST_SHIFT;
  localparam logic [2:0] DONE  = ST_DONE;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_tc;

  assign cnt_clr = (state == LOAD);
  assign cnt_inc = (state == SHIFT);

  iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .tc    (cnt_tc)
  );

`ifdef MERGE_ADD_SHIFT_EN
  logic q0_r;

  // Capture the current multiplier bit so SHIFT can add and shift together.
  always_ff @(posedge clk) begin
    if (reset) begin
      q0_r <= 1'b0;
    end else if (state == CHECK) begin
      q0_r <= q0;
    end
  end
`endif

  // State register; reset overrides any pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:  state_nxt = start ? LOAD : IDLE;
      LOAD:  state_nxt = CHECK;
`ifdef MERGE_ADD_SHIFT_EN
      CHECK: state_nxt = SHIFT;
      ADD:   state_nxt = IDLE;
`else
      CHECK: state_nxt = q0 ? ADD : SHIFT;
      ADD:   state_nxt = SHIFT;
`endif
      SHIFT: state_nxt = cnt_tc ? DONE : CHECK;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    load_regs = 1'b0;
    clr_acc   = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD: begin
        load_regs = 1'b1;
        clr_acc   = 1'b1;
        busy      = 1'b1;
      end
      CHECK: busy = 1'b1;
`ifndef MERGE_ADD_SHIFT_EN
      ADD: begin
        add_en = 1'b1;
        busy   = 1'b1;
      end
`endif
      SHIFT: begin
`ifdef MERGE_ADD_SHIFT_EN
        add_en   = q0_r;
`endif
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : tb_shift_add_mult_ctrl
// Purpose  : Self-checking bench for shift_add_mult_ctrl. A behavioural
//            A:Q:M datapath follows the controller's enables so the final
//            product can be compared with plain multiplication; cycle
//            timing is compared with the closed-form latency.
// Options  : MERGE_ADD_SHIFT_EN - expectations follow the merged variant.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_shift_add_mult_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic q0;
  logic load_regs, clr_acc, add_en, shift_en, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q0        (q0),
    .load_regs (load_regs),
    .clr_acc   (clr_acc),
    .add_en    (add_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural datapath: carry+A (W+1 bits), Q, multiplicand M.
  logic [W:0]   dp_a = '0;
  logic [W-1:0] dp_q = '0;
  logic [W-1:0] dp_m = '0;
  logic [W-1:0] mult_in = '0;
  logic [W-1:0] mcand_in = '0;

  assign q0 = dp_q[0];

  // Datapath follows the enables: clear, then add, then shift right.
  always @(posedge clk) begin : datapath
    logic [W:0]   a_next;
    logic [2*W:0] acq;
    a_next = dp_a;
    if (clr_acc) a_next = '0;
    if (add_en)  a_next = {1'b0, a_next[W-1:0]} + {1'b0, dp_m};
    acq = {a_next, dp_q};
    if (shift_en) acq = acq >> 1;
    dp_a <= acq[2*W:W];
    dp_q <= load_regs ? mult_in  : acq[W-1:0];
    dp_m <= load_regs ? mcand_in : dp_m;
  end

  // Observations collected by run_op.
  int load_cyc, clr_cyc, done_cyc, done_cnt;
  int add_cnt, shift_cnt, both_cnt, order_err;
  bit abort_ok, timed_out;
  logic [2*W-1:0] product;

  function automatic int exp_done_cycle(input logic [W-1:0] m);
`ifdef MERGE_ADD_SHIFT_EN
    return 2 + 2 * W;
`else
    return 2 + 2 * W + $countones(m);
`endif
  endfunction

  function automatic int exp_both(input logic [W-1:0] m);
`ifdef MERGE_ADD_SHIFT_EN
    return $countones(m);
`else
    return (m == m) ? 0 : 0;
`endif
  endfunction

  // Start one operation in cycle 0 and observe it until the controller idles.
  task automatic run_op(input logic [W-1:0] mult, input logic [W-1:0] mcand,
                        input int restart_cyc, input int abort_shift);
    int cyc;
    bit prev_add;
    bit abort_pending;
    load_cyc = -1; clr_cyc = -1; done_cyc = -1; done_cnt = 0;
    add_cnt = 0; shift_cnt = 0; both_cnt = 0; order_err = 0;
    abort_ok = 1'b0; timed_out = 1'b0; product = '0;
    prev_add = 1'b0; abort_pending = 1'b0;
    @(negedge clk);
    mult_in = mult; mcand_in = mcand; start = 1'b1; cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_cyc);
      if (abort_pending) begin
        abort_ok = !(load_regs || clr_acc || add_en || shift_en || busy || done);
        reset = 1'b0;
        break;
      end
      if (load_regs && load_cyc < 0) load_cyc = cyc;
      if (clr_acc && clr_cyc < 0) clr_cyc = cyc;
      if (add_en) add_cnt++;
      if (shift_en) shift_cnt++;
      if (add_en && shift_en) both_cnt++;
      if (prev_add && !shift_en) order_err++;
      prev_add = add_en && !shift_en;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        product = {dp_a[W-1:0], dp_q};
      end
      if (abort_shift > 0 && shift_en && shift_cnt == abort_shift) begin
        reset = 1'b1;
        abort_pending = 1'b1;
      end
      if (cyc > 1 && !busy) break;
      if (cyc > 200) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({load_regs, clr_acc, add_en, shift_en, busy, done} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs got %b expected 000000",
                 {load_regs, clr_acc, add_en, shift_en, busy, done});
      end
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_regs, clr_acc, add_en, shift_en, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL post_reset_idle got %b expected 000000",
               {load_regs, clr_acc, add_en, shift_en, busy, done});
    end
  endtask

  task automatic test_patterns;
    logic [W-1:0] mults [8];
    mults[0] = 8'h00; mults[1] = 8'hFF; mults[2] = 8'h55; mults[3] = 8'hAA;
    for (int i = 4; i < 8; i++) mults[i] = W'($urandom);
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] m, mc;
      logic [2*W-1:0] exp_p;
      m = mults[i];
      mc = W'($urandom);
      exp_p = (2*W)'(m) * (2*W)'(mc);
      run_op(m, mc, 0, 0);
      checks++;
      if (timed_out) begin
        errors++;
        $display("FAIL op_timeout m=%h got timeout expected completion", m);
      end
      checks++;
      if (load_cyc !== 1 || clr_cyc !== 1) begin
        errors++;
        $display("FAIL load_cycle m=%h got load=%0d clr=%0d expected 1/1", m, load_cyc, clr_cyc);
      end
      checks++;
      if (done_cyc !== exp_done_cycle(m) || done_cnt !== 1) begin
        errors++;
        $display("FAIL done_cycle m=%h got cycle %0d count %0d expected cycle %0d count 1",
                 m, done_cyc, done_cnt, exp_done_cycle(m));
      end
      checks++;
      if (add_cnt !== $countones(m) || shift_cnt !== W) begin
        errors++;
        $display("FAIL enable_counts m=%h got add=%0d shift=%0d expected add=%0d shift=%0d",
                 m, add_cnt, shift_cnt, $countones(m), W);
      end
      checks++;
      if (both_cnt !== exp_both(m) || order_err !== 0) begin
        errors++;
        $display("FAIL add_shift_order m=%h got coincident=%0d order_err=%0d expected %0d/0",
                 m, both_cnt, order_err, exp_both(m));
      end
      checks++;
      if (product !== exp_p) begin
        errors++;
        $display("FAIL product m=%h mc=%h got %h expected %h", m, mc, product, exp_p);
      end
    end
  endtask

  task automatic test_restart_ignored;
    logic [W-1:0] m, mc;
    m = W'($urandom);
    mc = W'($urandom);
    run_op(m, mc, 5, 0);
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done_cycle(m)) begin
      errors++;
      $display("FAIL restart_ignored m=%h got count %0d cycle %0d expected count 1 cycle %0d",
               m, done_cnt, done_cyc, exp_done_cycle(m));
    end
    checks++;
    if (product !== (2*W)'(m) * (2*W)'(mc)) begin
      errors++;
      $display("FAIL restart_product got %h expected %h", product, (2*W)'(m) * (2*W)'(mc));
    end
  endtask

  task automatic test_abort;
    logic [W-1:0] m, mc;
    m = W'($urandom);
    mc = W'($urandom);
    run_op(m, mc, 0, 4);
    checks++;
    if (done_cnt !== 0 || !abort_ok || timed_out) begin
      errors++;
      $display("FAIL abort got done_count %0d idle_after_reset %0d expected 0/1",
               done_cnt, abort_ok);
    end
    m = W'($urandom);
    mc = W'($urandom);
    run_op(m, mc, 0, 0);
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done_cycle(m) ||
        product !== (2*W)'(m) * (2*W)'(mc)) begin
      errors++;
      $display("FAIL after_abort m=%h got count %0d cycle %0d product %h expected 1 %0d %h",
               m, done_cnt, done_cyc, product, exp_done_cycle(m), (2*W)'(m) * (2*W)'(mc));
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] m;
    int cyc, first_done, second_load;
    m = W'($urandom);
    first_done = -1;
    second_load = -1;
    @(negedge clk);
    mult_in = m; mcand_in = W'($urandom); start = 1'b1; cyc = 0;
    while (second_load < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done && first_done < 0) first_done = cyc;
      if (load_regs && first_done >= 0) second_load = cyc;
    end
    start = 1'b0;
    checks++;
    if (first_done !== exp_done_cycle(m) || second_load !== exp_done_cycle(m) + 2) begin
      errors++;
      $display("FAIL back_to_back got done %0d reload %0d expected %0d %0d",
               first_done, second_load, exp_done_cycle(m), exp_done_cycle(m) + 2);
    end
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain got busy %b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
